// File: rtl/perf_multi.sv
// Multi-channel performance monitor: total/busy/idle plus NUM_EVENTS event counters,
// with one-shot (start..done) or windowed snapshot modes and sticky per-counter overflow.

module perf_counter #(
    parameter int W        = 32,
    parameter int SATURATE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr_all,
    input  logic         clr_win,
    input  logic         inc,
    output logic [W-1:0] cnt_nxt,
    output logic         ovf
);
    logic [W-1:0] cnt;
    logic         at_max;

    assign at_max = &cnt;

    // Value including this cycle's increment; also what a snapshot captures.
    always_comb begin
        cnt_nxt = cnt;
        if (inc && !(at_max && SATURATE != 0))
            cnt_nxt = cnt + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr_all) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            cnt <= clr_win ? '0 : cnt_nxt;
            if (inc && at_max)
                ovf <= 1'b1;
        end
    end
endmodule

module perf_multi #(
    parameter int COUNTER_WIDTH = 32,
    parameter int NUM_EVENTS    = 4,
    parameter int SATURATE      = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start_pulse,
    input  logic                                    done_pulse,
    input  logic                                    abort_pulse,
    input  logic                                    busy_signal,
    input  logic [NUM_EVENTS-1:0]                   event_inc,
    input  logic [COUNTER_WIDTH-1:0]                window_len,
    output logic [(NUM_EVENTS+3)*COUNTER_WIDTH-1:0] snapshot_data,
    output logic [NUM_EVENTS+2:0]                   overflow_flags,
    output logic                                    sample_valid,
    output logic                                    measuring
);
    localparam int W  = COUNTER_WIDTH;
    localparam int NC = NUM_EVENTS + 3;

    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_MEASURING = 1'b1;

    logic [0:0]            state;
    logic [W-1:0]          win_cnt, win_len_r;
    logic [NC-1:0]         inc_vec;
    logic [NC-1:0][W-1:0]  cnt_nxt, snap_r;
    logic                  meas, win_last;
    logic                  do_abort, do_done, do_exp, do_start;

    assign meas     = (state == S_MEASURING);
    assign win_last = (win_len_r != '0) && (win_cnt == win_len_r - W'(1));

    // abort > done > window expiry > start
    assign do_abort = meas && abort_pulse;
    assign do_done  = meas && !abort_pulse && done_pulse;
    assign do_exp   = meas && !abort_pulse && !done_pulse && win_last;
    assign do_start = start_pulse && (!meas || (!abort_pulse && !done_pulse && !win_last));

    assign inc_vec = {event_inc, ~busy_signal, busy_signal, 1'b1};

    genvar g;
    generate
        for (g = 0; g < NC; g++) begin : g_cnt
            perf_counter #(.W(W), .SATURATE(SATURATE)) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (meas),
                .clr_all (do_start),
                .clr_win (do_exp),
                .inc     (inc_vec[g]),
                .cnt_nxt (cnt_nxt[g]),
                .ovf     (overflow_flags[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            win_cnt      <= '0;
            win_len_r    <= '0;
            snap_r       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= do_done || do_exp;
            if (do_done || do_exp)
                snap_r <= cnt_nxt;

            if (do_start || do_exp)
                win_cnt <= '0;
            else if (meas)
                win_cnt <= win_cnt + W'(1);

            if (do_start)
                win_len_r <= window_len;

            if (do_abort || do_done)
                state <= S_IDLE;
            else if (do_start)
                state <= S_MEASURING;
        end
    end

    assign snapshot_data = snap_r;
    assign measuring     = meas;
endmodule
